// File: rtl/trx_sequencer.sv
// trx_sequencer: half-duplex pulse transceiver path sequencer.
// Break-before-make guard between TX and RX paths; all outputs registered.
module trx_sequencer #(
  parameter int GUARD_CYC   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Mode,
  input  logic i_Start,
  input  logic i_Rx_Data,
  input  logic i_Dac_Ready,
  input  logic i_Pulse_Done,
  output logic o_Dac_Start,
  output logic o_Pulse_Req,
  output logic o_Ant_Tx,
  output logic o_Amp_En,
  output logic o_Ant_Rx,
  output logic o_Rx_Pwr,
  output logic o_Lna_En,
  output logic o_Busy,
  output logic o_Done,
  output logic o_Timeout
);

  typedef enum logic [2:0] {
    INIT,
    DAC_WAIT,
    IDLE,
    TX_SETTLE,
    TX_FIRE,
    GUARD,
    RX_WAIT,
    DONE
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] GUARD_LAST  = 16'(GUARD_CYC - 1);
  localparam logic [15:0] TOUT_LAST   = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  state_t      gnext_q, gnext_d;
  logic        mode_q, mode_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tout_q, tout_d;

  logic start_s1_q, start_s2_q, start_s3_q;
  logic rx_s1_q, rx_s2_q, rx_s3_q;

  logic dac_q, preq_q, ant_tx_q, amp_q;
  logic ant_rx_q, rx_pwr_q, lna_q;
  logic busy_q, done_q;

  logic start_rise;
  logic rx_fall;
  logic tx_on_d;
  logic rx_on_d;

  assign start_rise = start_s2_q & ~start_s3_q;
  assign rx_fall    = ~rx_s2_q & rx_s3_q;

  // GUARD destination is decided by whoever enters it
  always_comb begin
    state_d = state_q;
    gnext_d = gnext_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    unique case (state_q)
      INIT: state_d = DAC_WAIT;
      DAC_WAIT: begin
        if (i_Dac_Ready) state_d = IDLE;
      end
      IDLE: begin
        if (start_rise) begin
          mode_d = i_Mode;
          tout_d = 1'b0;
          cnt_d  = '0;
          if (i_Mode) begin
            state_d = TX_SETTLE;
          end else begin
            state_d = GUARD;
            gnext_d = RX_WAIT;
          end
        end
      end
      TX_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = TX_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      TX_FIRE: begin
        if (i_Pulse_Done) begin
          state_d = GUARD;
          gnext_d = mode_q ? RX_WAIT : DONE;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = gnext_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_WAIT: begin
        if (rx_fall) begin
          cnt_d = '0;
          if (mode_q) begin
            state_d = DONE;
          end else begin
            state_d = GUARD;
            gnext_d = TX_SETTLE;
          end
        end else if (cnt_q == TOUT_LAST) begin
          state_d = DONE;
          tout_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  assign tx_on_d = (state_d == TX_SETTLE) || (state_d == TX_FIRE);
  assign rx_on_d = (state_d == RX_WAIT);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= INIT;
      gnext_q    <= INIT;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      tout_q     <= 1'b0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_s3_q    <= 1'b0;
      dac_q      <= 1'b0;
      preq_q     <= 1'b0;
      ant_tx_q   <= 1'b0;
      amp_q      <= 1'b0;
      ant_rx_q   <= 1'b0;
      rx_pwr_q   <= 1'b0;
      lna_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_s1_q <= i_Start;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      rx_s1_q    <= i_Rx_Data;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      state_q    <= state_d;
      gnext_q    <= gnext_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      dac_q      <= (state_q == INIT);
      preq_q     <= (state_d == TX_FIRE) && (state_q != TX_FIRE);
      ant_tx_q   <= tx_on_d;
      amp_q      <= tx_on_d;
      ant_rx_q   <= rx_on_d;
      rx_pwr_q   <= rx_on_d;
      lna_q      <= rx_on_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign o_Dac_Start = dac_q;
  assign o_Pulse_Req = preq_q;
  assign o_Ant_Tx    = ant_tx_q;
  assign o_Amp_En    = amp_q;
  assign o_Ant_Rx    = ant_rx_q;
  assign o_Rx_Pwr    = rx_pwr_q;
  assign o_Lna_En    = lna_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Timeout   = tout_q;

endmodule

// File: tb/tb_trx_sequencer.sv
// tb_trx_sequencer: randomized scenarios against a timeline model
// built from the sequencing rules (phase start/end cycle arithmetic).
module tb_trx_sequencer;

  localparam int S = 8;
  localparam int G = 4;
  localparam int T = 5000;

  logic clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Mode = 1'b0;
  logic i_Start = 1'b0;
  logic i_Rx_Data = 1'b0;
  logic i_Dac_Ready = 1'b0;
  logic i_Pulse_Done = 1'b0;
  logic o_Dac_Start, o_Pulse_Req, o_Ant_Tx, o_Amp_En;
  logic o_Ant_Rx, o_Rx_Pwr, o_Lna_En;
  logic o_Busy, o_Done, o_Timeout;

  int n_tests = 0;
  int n_fail = 0;

  // timeline of the current scenario, in observation cycles
  int m_b0, m_ts, m_tf, m_pd, m_rxlo, m_rxhi, m_done;
  logic m_tprev = 1'b0;
  logic m_tnew = 1'b0;

  trx_sequencer #(
    .GUARD_CYC(G),
    .SETTLE_CYC(S),
    .TIMEOUT_CYC(T)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(i_Rst_L),
    .i_Mode(i_Mode),
    .i_Start(i_Start),
    .i_Rx_Data(i_Rx_Data),
    .i_Dac_Ready(i_Dac_Ready),
    .i_Pulse_Done(i_Pulse_Done),
    .o_Dac_Start(o_Dac_Start),
    .o_Pulse_Req(o_Pulse_Req),
    .o_Ant_Tx(o_Ant_Tx),
    .o_Amp_En(o_Amp_En),
    .o_Ant_Rx(o_Ant_Rx),
    .o_Rx_Pwr(o_Rx_Pwr),
    .o_Lna_En(o_Lna_En),
    .o_Busy(o_Busy),
    .o_Done(o_Done),
    .o_Timeout(o_Timeout)
  );

  always #10 clk = ~clk;

  // {dac, preq, ant_tx, amp, ant_rx, rx_pwr, lna, busy, done, timeout}
  function automatic logic [9:0] outvec();
    return {o_Dac_Start, o_Pulse_Req, o_Ant_Tx, o_Amp_En, o_Ant_Rx,
            o_Rx_Pwr, o_Lna_En, o_Busy, o_Done, o_Timeout};
  endfunction

  function automatic logic [9:0] exp_at(input int k);
    logic tx, rx, tout;
    tx = (k >= m_ts) && (k <= m_pd);
    rx = (k >= m_rxlo) && (k <= m_rxhi);
    if (k < m_b0) tout = m_tprev;
    else if (k < m_done) tout = 1'b0;
    else tout = m_tnew;
    return {1'b0, k == m_tf, tx, tx, rx, rx, rx,
            (k >= m_b0) && (k <= m_done), k == m_done, tout};
  endfunction

  logic prev_tx = 1'b0;
  logic prev_preq = 1'b0;
  always @(negedge clk) begin
    if (i_Rst_L) begin
      assert (!((o_Ant_Tx | o_Amp_En) && (o_Ant_Rx | o_Rx_Pwr | o_Lna_En)))
      else begin
        n_fail++;
        $display("FAIL tx_rx_overlap: tx=%b%b rx=%b%b%b, required no overlap",
                 o_Ant_Tx, o_Amp_En, o_Ant_Rx, o_Rx_Pwr, o_Lna_En);
      end
      assert (!o_Pulse_Req || (o_Ant_Tx && o_Amp_En && prev_tx && !prev_preq))
      else begin
        n_fail++;
        $display("FAIL preq_outside_fire: preq=1 prev_tx=%b prev_preq=%b, required first TX_FIRE cycle",
                 prev_tx, prev_preq);
      end
    end
    prev_tx   <= o_Ant_Tx && o_Amp_En && i_Rst_L;
    prev_preq <= o_Pulse_Req;
  end

  task automatic test_reset();
    logic [9:0] act;
    i_Rst_L = 1'b0;
    repeat (3) @(negedge clk);
    act = outvec();
    n_tests++;
    if (act !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", act, 10'b0);
    end
  endtask

  task automatic test_dac_init(input string nm, input int rdy);
    logic [9:0] act;
    int dac_cnt, dac_first;
    logic busy_r, busy_r1, busy_late;
    dac_cnt = 0;
    dac_first = -1;
    busy_r = 1'b0;
    busy_r1 = 1'b1;
    busy_late = 1'b0;
    @(negedge clk);
    i_Rst_L = 1'b1;
    i_Dac_Ready = 1'b0;
    for (int k = 1; k <= rdy + 12; k++) begin
      @(negedge clk);
      act = outvec();
      if (act[9]) begin
        dac_cnt++;
        if (dac_first < 0) dac_first = k;
      end
      if (k == rdy) busy_r = act[2];
      if (k == rdy + 1) busy_r1 = act[2];
      if (k > rdy + 1 && act[2]) busy_late = 1'b1;
      i_Dac_Ready = (k == rdy) || (k > rdy + 1 && 1'($urandom));
    end
    i_Dac_Ready = 1'b0;
    m_tprev = 1'b0;
    n_tests++;
    if (dac_first != 1) begin
      n_fail++;
      $display("FAIL %s dac_first: got cycle %0d required 1", nm, dac_first);
    end
    n_tests++;
    if (dac_cnt != 1) begin
      n_fail++;
      $display("FAIL %s dac_once: got %0d pulses required 1", nm, dac_cnt);
    end
    n_tests++;
    if (busy_r !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_before_ready: got %b required 1", nm, busy_r);
    end
    n_tests++;
    if (busy_r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_ready: got busy=%b required 0", nm, busy_r1);
    end
    n_tests++;
    if (busy_late !== 1'b0) begin
      n_fail++;
      $display("FAIL %s stays_idle: got busy=%b required 0", nm, busy_late);
    end
  endtask

  // roff/len place the echo pulse relative to RX_WAIT entry; len=0: none
  task automatic test_exchange(input string nm, input bit mode,
                               input int roff, input int len, input bit extra);
    int s0, dly, r0, r1, f, lim, x0, bad;
    logic [9:0] act, expv, a_bad, e_bad;
    bit hit;
    s0 = 1 + int'($urandom_range(0, 2));
    dly = int'($urandom_range(0, 5));
    m_b0 = s0 + 3;
    m_ts = -10;
    m_tf = -10;
    m_pd = -11;
    if (mode) begin
      m_ts = m_b0;
      m_tf = m_ts + S;
      m_pd = m_tf + dly;
      m_rxlo = m_pd + 1 + G;
    end else begin
      m_rxlo = m_b0 + G;
    end
    r0 = m_rxlo + roff;
    r1 = r0 + len;
    if (r0 < 0) r0 = 0;
    f = r1 + 2;
    hit = (r1 > r0) && (f >= m_rxlo) && (f <= m_rxlo + T - 1);
    if (hit) begin
      m_rxhi = f;
      m_tnew = 1'b0;
      if (mode) begin
        m_done = f + 1;
      end else begin
        m_ts = f + 1 + G;
        m_tf = m_ts + S;
        m_pd = m_tf + dly;
        m_done = m_pd + 1 + G;
      end
    end else begin
      m_rxhi = m_rxlo + T - 1;
      m_done = m_rxlo + T;
      m_tnew = 1'b1;
    end
    x0 = m_b0 + 2 + int'($urandom_range(0, 4));
    lim = ((m_done > r1) ? m_done : r1) + 5;
    bad = -1;
    act = '0;
    expv = '0;
    a_bad = '0;
    e_bad = '0;
    for (int k = 0; k <= lim; k++) begin
      @(negedge clk);
      act = outvec();
      expv = exp_at(k);
      if (bad < 0 && act !== expv) begin
        bad = k;
        a_bad = act;
        e_bad = expv;
      end
      i_Start = (k >= s0 && k < s0 + 4) || (extra && k >= x0 && k < x0 + 2);
      i_Mode = (k <= s0 + 2) ? mode : 1'($urandom);
      i_Rx_Data = (k >= r0) && (k < r1);
      i_Pulse_Done = (k == m_pd) ||
                     ((k < m_tf || k > m_pd) && $urandom_range(0, 7) == 0);
      i_Dac_Ready = 1'($urandom);
    end
    i_Start = 1'b0;
    i_Rx_Data = 1'b0;
    i_Pulse_Done = 1'b0;
    i_Dac_Ready = 1'b0;
    if (bad < 0) begin
      a_bad = act;
      e_bad = expv;
    end
    n_tests++;
    if (a_bad !== e_bad) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %b required %b", nm, bad, a_bad, e_bad);
    end
    m_tprev = m_tnew;
  endtask

  task automatic test_initiator();
    test_exchange("initiator_echo", 1'b1, 300, 5, 1'b0);
    test_exchange("initiator_timeout", 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_responder();
    test_exchange("responder_reply", 1'b0, 5, 10, 1'b0);
    test_exchange("responder_timeout", 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_boundaries();
    test_exchange("edge_first_rx_cycle", 1'b1, -6, 4, 1'b0);
    test_exchange("edge_first_rx_cycle_resp", 1'b0, -6, 4, 1'b0);
    test_exchange("edge_beats_timeout", 1'b1, T - 7, 4, 1'b0);
    test_exchange("early_fall_ignored", 1'b1, -10, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_exchange("start_while_busy", 1'b1, 50, 6, 1'b1);
    test_exchange("start_while_busy_resp", 1'b0, 20, 6, 1'b1);
  endtask

  task automatic test_random();
    int len;
    for (int i = 0; i < 10; i++) begin
      len = int'($urandom_range(1, 20));
      test_exchange("random", 1'($urandom),
                    int'($urandom_range(0, 400)) - len - 2, len, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_fire();
    logic [9:0] act, expv, a_bad, e_bad;
    int bad;
    m_b0 = 4;
    m_ts = 4;
    m_tf = 4 + S;
    m_pd = m_tf + 1000;
    m_rxlo = 100000;
    m_rxhi = -1;
    m_done = 100000;
    m_tnew = 1'b0;
    bad = -1;
    act = '0;
    expv = '0;
    a_bad = '0;
    e_bad = '0;
    for (int k = 0; k <= m_tf + 1; k++) begin
      @(negedge clk);
      act = outvec();
      expv = exp_at(k);
      if (bad < 0 && act !== expv) begin
        bad = k;
        a_bad = act;
        e_bad = expv;
      end
      i_Start = (k >= 1 && k < 5);
      i_Mode = 1'b1;
      i_Pulse_Done = 1'b0;
    end
    if (bad < 0) begin
      a_bad = act;
      e_bad = expv;
    end
    n_tests++;
    if (a_bad !== e_bad) begin
      n_fail++;
      $display("FAIL midfire_tx: cycle %0d got %b required %b", bad, a_bad, e_bad);
    end
    #3 i_Rst_L = 1'b0;
    #1 act = outvec();
    n_tests++;
    if (act !== 10'b0) begin
      n_fail++;
      $display("FAIL midfire_reset: got %b required %b", act, 10'b0);
    end
    test_dac_init("reinit", 5 + int'($urandom_range(0, 9)));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dac_init("init", 20);
    test_initiator();
    test_responder();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_reset_mid_fire();
    test_exchange("after_reinit", 1'b1, 40, 3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
